// File: rtl/exe_unit_w6_core.sv
// Sign-magnitude execution unit: subtract / compare / shift / bit toggle,
// with the result and a 4-bit status word registered one cycle after the inputs.
module exe_unit_w6_core #(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  input  logic [1:0]      i_op,
  output logic [BITS-1:0] o_out,
  output logic [3:0]      o_status
);
  localparam int MW = BITS - 1;
  localparam logic [MW-1:0] MAG_MAX = '1;
  localparam logic [MW:0]   MW_V    = (MW+1)'(MW);
  localparam logic [BITS:0] BITS_V  = (BITS+1)'(BITS);

  typedef enum logic [1:0] {OP_SUB = 2'b00, OP_CMP = 2'b01, OP_SHL = 2'b10, OP_TGL = 2'b11} op_e;

  typedef struct packed {
    logic [BITS-1:0] res;
    logic [3:0]      st;   // {SINGLE, EVEN, OVF, ERR}
  } rsp_t;

  // Operands with negative zero folded onto +0
  logic [MW-1:0] mag_a, mag_b;
  logic          sgn_a, sgn_b;
  assign mag_a = in_a[MW-1:0];
  assign mag_b = in_b[MW-1:0];
  assign sgn_a = in_a[BITS-1] & (|mag_a);
  assign sgn_b = in_b[BITS-1] & (|mag_b);

  logic signed [BITS:0] val_a, val_b, diff;
  logic [BITS:0]        diff_mag;
  assign val_a    = sgn_a ? -$signed({2'b00, mag_a}) : $signed({2'b00, mag_a});
  assign val_b    = sgn_b ? -$signed({2'b00, mag_b}) : $signed({2'b00, mag_b});
  assign diff     = val_a - val_b;
  assign diff_mag = diff[BITS] ? $unsigned(-diff) : $unsigned(diff);

  // Shift in a double-width field so every bit leaving the magnitude is visible
  logic [2*MW-1:0] shl_ext;
  logic            shl_big;
  assign shl_big = {1'b0, mag_b} >= MW_V;
  assign shl_ext = {{MW{1'b0}}, mag_a} << mag_b;

  rsp_t            rsp;
  logic [BITS-1:0] r;
  logic            err, ovf;
  int              pc;

  always_comb begin
    r   = '0;
    err = 1'b0;
    ovf = 1'b0;
    unique case (op_e'(i_op))
      OP_SUB: begin
        ovf = diff_mag > {2'b00, MAG_MAX};
        r   = {diff[BITS], ovf ? MAG_MAX : diff_mag[MW-1:0]};
      end
      OP_CMP: r = BITS'(val_a > val_b);
      OP_SHL: begin
        err = in_b[BITS-1];
        if (shl_big) begin
          ovf = |mag_a;
          r   = {sgn_a, {MW{1'b0}}};
        end else begin
          ovf = |shl_ext[2*MW-1:MW];
          r   = {sgn_a, shl_ext[MW-1:0]};
        end
      end
      OP_TGL: begin
        err = {1'b0, in_b} >= BITS_V;
        r   = {sgn_a, mag_a} ^ (BITS'(1) << in_b);
      end
      default: r = '0;
    endcase
    if (r[MW-1:0] == '0) r[BITS-1] = 1'b0;
    if (err) begin
      r   = '0;
      ovf = 1'b0;
    end
    pc         = $countones(r);
    rsp.res    = r;
    rsp.st[0]  = err;
    rsp.st[1]  = ovf;
    rsp.st[2]  = ~err & ~pc[0];
    rsp.st[3]  = ~err & (pc == 1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out    <= '0;
      o_status <= '0;
    end else begin
      o_out    <= rsp.res;
      o_status <= rsp.st;
    end
  end
endmodule

// File: tb/tb_exe_unit_w6_core.sv
// Directed bench for exe_unit_w6_core (BITS=8): per-op vectors, latency,
// back-to-back opcodes and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_exe_unit_w6_core;
  logic       i_clk;
  logic       i_rst;
  logic [7:0] in_a, in_b;
  logic [1:0] i_op;
  logic [7:0] o_out;
  logic [3:0] o_status;

  int checks = 0;
  int errors = 0;

  exe_unit_w6_core #(.BITS(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .in_a(in_a), .in_b(in_b),
    .i_op(i_op), .o_out(o_out), .o_status(o_status)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    @(negedge i_clk);
    in_a = a; in_b = b; i_op = op;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; in_a = 8'h5B; in_b = 8'h29; i_op = 2'b00;
    #2;
    checks++;
    if (o_out !== 8'h00 || o_status !== 4'h0) begin
      errors++;
      $display("FAIL reset_initial out=%h st=%b expected out=00 st=0000", o_out, o_status);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_out !== 8'h00 || o_status !== 4'h0) begin
      errors++;
      $display("FAIL reset_held out=%h st=%b expected out=00 st=0000", o_out, o_status);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_subtract();
    logic [7:0] ta [6] = '{8'hFF, 8'h7F, 8'h5B, 8'h05, 8'h03, 8'h80};
    logic [7:0] tb [6] = '{8'h01, 8'h81, 8'h29, 8'h05, 8'h05, 8'h80};
    logic [7:0] eo [6] = '{8'hFF, 8'h7F, 8'h32, 8'h00, 8'h82, 8'h00};
    logic [3:0] es [6] = '{4'b0110, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
    for (int i = 0; i < 6; i++) begin
      step(ta[i], tb[i], 2'b00);
      checks++;
      if (o_out !== eo[i] || o_status !== es[i]) begin
        errors++;
        $display("FAIL sub[%0d] a=%h b=%h out=%h st=%b expected out=%h st=%b",
                 i, ta[i], tb[i], o_out, o_status, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_compare();
    logic [7:0] ta [5] = '{8'hB2, 8'h5A, 8'h80, 8'h81, 8'h05};
    logic [7:0] tb [5] = '{8'h04, 8'h28, 8'h00, 8'h82, 8'h05};
    logic [7:0] eo [5] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
    logic [3:0] es [5] = '{4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      step(ta[i], tb[i], 2'b01);
      checks++;
      if (o_out !== eo[i] || o_status !== es[i]) begin
        errors++;
        $display("FAIL cmp[%0d] a=%h b=%h out=%h st=%b expected out=%h st=%b",
                 i, ta[i], tb[i], o_out, o_status, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0] ta [8] = '{8'hC1, 8'h09, 8'hFF, 8'h06, 8'h81, 8'h01, 8'h80, 8'h40};
    logic [7:0] tb [8] = '{8'h81, 8'h01, 8'h01, 8'h05, 8'h02, 8'h07, 8'h03, 8'h01};
    logic [7:0] eo [8] = '{8'h00, 8'h12, 8'hFE, 8'h40, 8'h84, 8'h00, 8'h00, 8'h00};
    logic [3:0] es [8] = '{4'b0001, 4'b0100, 4'b0010, 4'b1010, 4'b0100, 4'b0110, 4'b0100, 4'b0110};
    for (int i = 0; i < 8; i++) begin
      step(ta[i], tb[i], 2'b10);
      checks++;
      if (o_out !== eo[i] || o_status !== es[i]) begin
        errors++;
        $display("FAIL shl[%0d] a=%h b=%h out=%h st=%b expected out=%h st=%b",
                 i, ta[i], tb[i], o_out, o_status, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_toggle();
    logic [7:0] ta [7] = '{8'h00, 8'h00, 8'hB0, 8'h00, 8'h66, 8'h00, 8'h00};
    logic [7:0] tb [7] = '{8'h81, 8'h70, 8'h00, 8'h03, 8'h03, 8'h07, 8'h08};
    logic [7:0] eo [7] = '{8'h00, 8'h00, 8'hB1, 8'h08, 8'h6E, 8'h00, 8'h00};
    logic [3:0] es [7] = '{4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b0000, 4'b0100, 4'b0001};
    for (int i = 0; i < 7; i++) begin
      step(ta[i], tb[i], 2'b11);
      checks++;
      if (o_out !== eo[i] || o_status !== es[i]) begin
        errors++;
        $display("FAIL tgl[%0d] a=%h b=%h out=%h st=%b expected out=%h st=%b",
                 i, ta[i], tb[i], o_out, o_status, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_latency();
    step(8'h5B, 8'h29, 2'b00);
    @(negedge i_clk);
    in_a = 8'h06; in_b = 8'h05; i_op = 2'b10;
    #1;
    checks++;
    if (o_out !== 8'h32 || o_status !== 4'b0000) begin
      errors++;
      $display("FAIL latency_hold out=%h st=%b expected out=32 st=0000", o_out, o_status);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_out !== 8'h40 || o_status !== 4'b1010) begin
      errors++;
      $display("FAIL latency_load out=%h st=%b expected out=40 st=1010", o_out, o_status);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [5] = '{8'h5B, 8'h5A, 8'h09, 8'h66, 8'h03};
    logic [7:0] tb [5] = '{8'h29, 8'h28, 8'h01, 8'h03, 8'h05};
    logic [1:0] to [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic [7:0] eo [5] = '{8'h32, 8'h01, 8'h12, 8'h6E, 8'h82};
    logic [3:0] es [5] = '{4'b0000, 4'b1000, 4'b0100, 4'b0000, 4'b0100};
    for (int i = 0; i < 5; i++) begin
      step(ta[i], tb[i], to[i]);
      checks++;
      if (o_out !== eo[i] || o_status !== es[i]) begin
        errors++;
        $display("FAIL b2b[%0d] op=%b out=%h st=%b expected out=%h st=%b",
                 i, to[i], o_out, o_status, eo[i], es[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(8'h5B, 8'h29, 2'b00);
    @(negedge i_clk);
    in_a = 8'h06; in_b = 8'h05; i_op = 2'b10;
    #1 i_rst = 1'b1;
    #1;
    checks++;
    if (o_out !== 8'h00 || o_status !== 4'h0) begin
      errors++;
      $display("FAIL reset_async out=%h st=%b expected out=00 st=0000", o_out, o_status);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_out !== 8'h00 || o_status !== 4'h0) begin
      errors++;
      $display("FAIL reset_discard out=%h st=%b expected out=00 st=0000", o_out, o_status);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if (o_out !== 8'h40 || o_status !== 4'b1010) begin
      errors++;
      $display("FAIL reset_release out=%h st=%b expected out=40 st=1010", o_out, o_status);
    end
  endtask

  initial begin
    test_reset();
    test_subtract();
    test_compare();
    test_shift();
    test_toggle();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
